// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is cut into STAGES equal slices,
// one register stage per slice, with a valid/ready handshake and full backpressure.
module pipe_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_sub,
  input  logic             i_Cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_S,
  output logic             o_C,
  output logic             o_V,
  output logic             o_Z
);

  localparam int unsigned CH   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [STAGES:0]  adv;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_in;

  assign b_eff = i_sub ? ~i_B : i_B;
  assign c0    = i_sub ? ~i_Cin : i_Cin;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv         = '0;
    adv[STAGES] = i_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end
  end

  always_comb begin
    v_in    = '0;
    v_in[0] = i_valid;
    for (int k = 1; k < int'(STAGES); k++) begin
      v_in[k] = v_q[k-1];
    end
  end

  assign o_ready = adv[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (adv[k]) v_q[k] <= v_in[k];
      end
    end
  end

  // Stage k sees only the operand bits not yet consumed (RW wide) plus the sum so far.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned RW = WIDTH - k * CH;

    logic [RW-1:0]         a_rem;
    logic [RW-1:0]         b_rem;
    logic                  c_in;
    logic [CH:0]           part;
    logic [(k+1)*CH-1:0]   s_nx;

    if (k == 0) begin : g_in
      assign a_rem = i_A;
      assign b_rem = b_eff;
      assign c_in  = c0;
      assign s_nx  = part[CH-1:0];
    end else begin : g_reg
      logic [RW-1:0]   a_q;
      logic [RW-1:0]   b_q;
      logic            c_q;
      logic [k*CH-1:0] s_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          s_q <= '0;
        end else if (adv[k-1] && v_in[k-1]) begin
          a_q <= g_stage[k-1].a_rem[RW+CH-1:CH];
          b_q <= g_stage[k-1].b_rem[RW+CH-1:CH];
          c_q <= g_stage[k-1].part[CH];
          s_q <= g_stage[k-1].s_nx;
        end
      end

      assign a_rem = a_q;
      assign b_rem = b_q;
      assign c_in  = c_q;
      assign s_nx  = {part[CH-1:0], s_q};
    end

    assign part = {1'b0, a_rem[CH-1:0]} + {1'b0, b_rem[CH-1:0]} + {{CH{1'b0}}, c_in};
  end

  logic [WIDTH-1:0] s_fin;
  logic             c_fin;
  logic             a_msb;
  logic             b_msb;
  logic             v_fin;
  logic             z_fin;

  // Flags come from the last slice's combinational sum, so they share its register.
  always_comb begin
    s_fin = g_stage[LAST].s_nx;
    c_fin = g_stage[LAST].part[CH];
    a_msb = g_stage[LAST].a_rem[CH-1];
    b_msb = g_stage[LAST].b_rem[CH-1];
    v_fin = (a_msb == b_msb) && (s_fin[WIDTH-1] != a_msb);
    z_fin = (s_fin == '0);
  end

  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             ovf_q;
  logic             z_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_q   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
      z_q   <= 1'b0;
    end else if (adv[LAST] && v_in[LAST]) begin
      s_q   <= s_fin;
      c_q   <= c_fin;
      ovf_q <= v_fin;
      z_q   <= z_fin;
    end
  end

  assign o_valid = v_q[LAST];
  assign o_S     = s_q;
  assign o_C     = c_q;
  assign o_V     = ovf_q;
  assign o_Z     = z_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and backpressure checks for pipe_addsub at WIDTH=16, STAGES=4.
module tb_pipe_addsub;

  localparam int unsigned W  = 16;
  localparam int unsigned ST = 4;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_A = '0;
  logic [W-1:0] i_B = '0;
  logic         i_sub = 1'b0;
  logic         i_Cin = 1'b0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [W-1:0] o_S;
  logic         o_C;
  logic         o_V;
  logic         o_Z;

  int checks = 0;
  int errors = 0;

  pipe_addsub #(
    .WIDTH (W),
    .STAGES(ST)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_A    (i_A),
    .i_B    (i_B),
    .i_sub  (i_sub),
    .i_Cin  (i_Cin),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_S    (o_S),
    .o_C    (o_C),
    .o_V    (o_V),
    .o_Z    (o_Z)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
    string       name;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Reference arithmetic at full width; returns {C, V, Z, S}.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic cin);
    logic [15:0] be;
    logic [16:0] r;
    logic        v;
    be = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + {16'b0, (sub ? ~cin : cin)};
    v  = (a[15] == be[15]) && (r[15] != a[15]);
    return {r[16], v, (r[15:0] == 16'h0000), r[15:0]};
  endfunction

  // One isolated op: result must appear exactly STAGES-1 edges after the accepting edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic cin, input logic [15:0] es, input logic ec,
                        input logic ev, input logic ez, input string name);
    int lat;
    @(negedge i_clk);
    i_A = a; i_B = b; i_sub = sub; i_Cin = cin;
    i_valid = 1'b1;
    i_ready = 1'b1;
    #1;
    check({name, " ready"}, 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_A = 16'($urandom);
    i_B = 16'($urandom);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(ST - 1));
    check({name, " result"}, 32'({o_C, o_V, o_Z, o_S}), 32'({ec, ev, ez, es}));
    @(posedge i_clk);
    #1;
    check({name, " single"}, 32'(o_valid), 32'd0);
  endtask

  logic [15:0] ra[10];
  logic [15:0] rb[10];
  logic        rs[10];
  logic        rc[10];
  logic [18:0] rexp[10];
  logic [19:0] held;
  logic        stalled;
  logic        acc;
  logic        dlv;
  logic        stale;
  int          sent;
  int          recv;
  int          occ;

  initial begin
    //         a         b         sub   cin   s         c     v     z
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, "add_basic"};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "add_wrap"};
    tbl[2] = '{16'hFFFE, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, "add_cin"};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_ovf_pos"};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, "add_ovf_neg"};
    tbl[5] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_neg"};
    tbl[6] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_ovf"};
    tbl[7] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, "sub_borrow"};
    tbl[8] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, "add_slice2"};
    tbl[9] = '{16'h0003, 16'h0003, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "sub_zero"};

    // Reset state
    #12;
    check("reset outputs", 32'({o_valid, o_C, o_V, o_Z, o_S}), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("reset ready", 32'(o_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin,
             tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].name);
    end

    // Back-to-back ops against random backpressure
    for (int i = 0; i < 10; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rs[i] = 1'($urandom);
      rc[i] = 1'($urandom);
      rexp[i] = model(ra[i], rb[i], rs[i], rc[i]);
    end
    sent = 0; recv = 0; occ = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
      @(negedge i_clk);
      i_ready = 1'($urandom);
      i_valid = (sent < 10);
      if (sent < 10) begin
        i_A = ra[sent]; i_B = rb[sent]; i_sub = rs[sent]; i_Cin = rc[sent];
      end
      #1;
      check("bp ready", 32'(o_ready), 32'((occ < int'(ST)) || i_ready));
      if (stalled) check("bp stall hold", 32'({o_valid, o_C, o_V, o_Z, o_S}), 32'(held));
      acc = i_valid && o_ready;
      dlv = o_valid && i_ready;
      if (dlv) begin
        check("bp result", 32'({o_C, o_V, o_Z, o_S}), 32'(rexp[recv]));
        recv++;
      end
      stalled = o_valid && !i_ready;
      held = {o_valid, o_C, o_V, o_Z, o_S};
      @(posedge i_clk);
      if (acc) begin
        sent++;
        occ++;
      end
      if (dlv) occ--;
    end
    check("bp delivered", 32'(recv), 32'd10);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    check("bp no extra", 32'(o_valid), 32'd0);

    // Reset with three ops in flight and a result waiting at the output
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_A = 16'(i + 1); i_B = 16'h0010; i_sub = 1'b0; i_Cin = 1'b0;
      i_valid = 1'b1;
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    check("rst pre valid", 32'(o_valid), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    check("rst async clear", 32'({o_valid, o_C, o_V, o_Z, o_S}), 32'd0);
    #1 i_rst = 1'b0;
    i_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clk);
      #1;
      stale = stale | o_valid;
    end
    check("rst no stale", 32'(stale), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
